// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature generator: FSM states and default sizing.
package quad_pkg;

    localparam int DEFAULT_WIDTH        = 8;
    localparam int DEFAULT_PHASE_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EDGE1 = 3'd1,
        ST_EDGE2 = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/phase_timer.sv
// Phase hold timer: counts PHASE_CYCLES-1 down to 0 after a load; expire is high while it reads 0.
module phase_timer #(
    parameter int PHASE_CYCLES = quad_pkg::DEFAULT_PHASE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expire
);

    localparam int TW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [TW-1:0] RELOAD = TW'(PHASE_CYCLES - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - TW'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/quad_gen.sv
// Quadrature A/B generator: walks a matched decoder's count to the requested target
// along the shorter direction around the WIDTH-bit wrap, one two-edge step at a time.
//
// Handshake: a request is taken on any rising edge where target_valid && target_ready;
// target is latched then. Requests arriving while busy are dropped, never queued.
module quad_gen
    import quad_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int PHASE_CYCLES = DEFAULT_PHASE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] target,
    input  logic             target_valid,
    output logic             target_ready,
    output logic             a,
    output logic             b,
    output logic [WIDTH-1:0] position,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_dbg
);

    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [WIDTH-1:0] target_q;
    logic             up_q;
    logic             expire;
    logic             load;
    logic             accept;
    logic [WIDTH-1:0] diff;
    logic             diff_up;

    assign accept  = target_valid && target_ready;
    assign diff    = target - position;
    // The exact half-way distance has no shorter side; it is resolved upward.
    assign diff_up = !diff[WIDTH-1] || (diff == HALF);
    assign load    = accept || (expire && (state == ST_EDGE1 || state == ST_EDGE2));

    phase_timer #(.PHASE_CYCLES(PHASE_CYCLES)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            a            <= 1'b0;
            b            <= 1'b0;
            position     <= '0;
            target_q     <= '0;
            up_q         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            target_ready <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        target_q     <= target;
                        up_q         <= diff_up;
                        target_ready <= 1'b0;
                        if (diff == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_EDGE1;
                            busy  <= 1'b1;
                        end
                    end
                end
                // Counting edge: A when stepping up, B when stepping down.
                ST_EDGE1: begin
                    if (expire) begin
                        if (up_q) begin
                            a        <= ~a;
                            position <= position + WIDTH'(1);
                        end else begin
                            b        <= ~b;
                            position <= position - WIDTH'(1);
                        end
                        state <= ST_EDGE2;
                    end
                end
                ST_EDGE2: begin
                    if (expire) begin
                        if (up_q) b <= ~b;
                        else      a <= ~a;
                        state <= (position == target_q) ? ST_HOLD : ST_EDGE1;
                    end
                end
                ST_HOLD: begin
                    if (expire) state <= ST_DONE;
                end
                ST_DONE: begin
                    done         <= 1'b1;
                    busy         <= 1'b0;
                    target_ready <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign state_dbg = state;

endmodule
